// File: rtl/alu_arbiter.sv
// Two-requester front end for a registered-output ALU: IDLE -> ISSUE -> RESULT, one op per 3 cycles.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 1 always wins contention.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a request transfers on a rising edge where reqX_valid && reqX_ready.
  // Requesters hold ctrl/a/b stable while valid is high and not yet accepted.
  typedef enum logic [1:0] {IDLE, ISSUE, RESULT} state_t;

  state_t           state, state_next;
  logic             owner;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             grant0, grant1;
  logic             accept;

`ifdef ALU_ARB_RR_EN
  logic last_served;

  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant0 = last_served;
      grant1 = !last_served;
    end
  end

  // Starts at 1 so the first contention after reset goes to requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_served <= 1'b1;
    end else if (accept) begin
      last_served <= req1_ready;
    end
  end
`else
  always_comb begin
    grant1 = req1_valid;
    grant0 = req0_valid && !req1_valid;
  end
`endif

  assign req0_ready = (state == IDLE) && !reset && grant0;
  assign req1_ready = (state == IDLE) && !reset && grant1;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_next = state;
    alu_ctrl   = 4'b0000;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE: begin
        alu_ctrl   = ctrl_q;
        alu_a      = a_q;
        alu_b      = b_q;
        state_next = RESULT;
      end
      RESULT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= 1'b0;
      ctrl_q <= 4'b0000;
      a_q    <= '0;
      b_q    <= '0;
    end else if (accept) begin
      owner  <= req1_ready;
      ctrl_q <= req1_ready ? req1_ctrl : req0_ctrl;
      a_q    <= req1_ready ? req1_a : req0_a;
      b_q    <= req1_ready ? req1_b : req0_b;
    end
  end

  // Result is captured from the ALU during RESULT and presented the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      op_count   <= '0;
    end else begin
      rsp0_valid <= (state == RESULT) && !owner;
      rsp1_valid <= (state == RESULT) && owner;
      rsp_data   <= (state == RESULT) ? alu_c : '0;
      if (state == RESULT) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU, a grant/latency model and a response queue.
module tb_alu_arbiter;
  localparam int W     = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid[2];
  logic [3:0]       req_ctrl[2];
  logic [W-1:0]     req_a[2];
  logic [W-1:0]     req_b[2];
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [W-1:0]     rsp_data, alu_a, alu_b, alu_c;
  logic [3:0]       alu_ctrl;
  logic [CNT_W-1:0] op_count;

  alu_arbiter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_ctrl(req_ctrl[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_ctrl(req_ctrl[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .busy(busy), .op_count(op_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // the ALU the arbiter drives: result registered on posedge
  always @(posedge clk) alu_c <= alu_ref(alu_ctrl, alu_a, alu_b);

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           owner_q[$];
  int           due_q[$];
  int           errors = 0;
  int           checks = 0;
  int           model_cnt = 0;
  int           idle_from = 0;
  int           iss_cyc = -10;
  bit           last = 1'b1;
  bit           hs[2];
  logic [3:0]   iss_ctrl;
  logic [W-1:0] iss_a, iss_b;

  always @(negedge clk) begin
    logic [W-1:0] d, ea, eb;
    logic [3:0]   ec;
    int           o, t, r;
    bit           g0, g1;
    if (reset) begin
      checks++;
      if (req0_ready || req1_ready) begin
        errors++;
        $display("FAIL ready_in_reset: got %b%b want 00", req1_ready, req0_ready);
      end
      exp_q.delete(); owner_q.delete(); due_q.delete();
      model_cnt = 0; last = 1'b1; idle_from = cyc + 1; iss_cyc = -10;
      hs[0] = 1'b0; hs[1] = 1'b0;
    end else begin
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: cyc=%0d rsp0=%b rsp1=%b data=%h", cyc, rsp0_valid, rsp1_valid, rsp_data);
        end else begin
          d = exp_q.pop_front(); o = owner_q.pop_front(); t = due_q.pop_front();
          model_cnt++;
          if ((rsp0_valid && rsp1_valid) || (rsp1_valid != (o == 1)) || rsp_data != d || t != cyc) begin
            errors++;
            $display("FAIL rsp: cyc=%0d got rsp0=%b rsp1=%b data=%h want owner=%0d data=%h at cyc=%0d",
                     cyc, rsp0_valid, rsp1_valid, rsp_data, o, d, t);
          end
        end
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL rsp_missing: cyc=%0d want owner=%0d data=%h", cyc, owner_q[0], exp_q[0]);
        void'(exp_q.pop_front()); void'(owner_q.pop_front()); void'(due_q.pop_front());
        model_cnt++;
      end
      checks++;
      if (op_count != CNT_W'(model_cnt)) begin
        errors++;
        $display("FAIL op_count: cyc=%0d got %0d want %0d", cyc, op_count, CNT_W'(model_cnt));
      end
      checks++;
      if (busy != (cyc < idle_from)) begin
        errors++;
        $display("FAIL busy: cyc=%0d got %b want %b", cyc, busy, (cyc < idle_from));
      end
      ec = 4'b0000; ea = '0; eb = '0;
      if (cyc == iss_cyc) begin ec = iss_ctrl; ea = iss_a; eb = iss_b; end
      checks++;
      if (alu_ctrl != ec || alu_a != ea || alu_b != eb) begin
        errors++;
        $display("FAIL alu_drive: cyc=%0d got %b/%h/%h want %b/%h/%h", cyc, alu_ctrl, alu_a, alu_b, ec, ea, eb);
      end
      g0 = 1'b0; g1 = 1'b0;
      if (cyc >= idle_from) begin
        if (req_valid[0] && req_valid[1]) begin
`ifdef ALU_ARB_RR_EN
          g0 = last; g1 = !last;
`else
          g1 = 1'b1;
`endif
        end else begin
          g0 = req_valid[0]; g1 = req_valid[1];
        end
      end
      checks++;
      if (req0_ready != g0 || req1_ready != g1) begin
        errors++;
        $display("FAIL grant: cyc=%0d got r1r0=%b%b want %b%b", cyc, req1_ready, req0_ready, g1, g0);
      end
      hs[0] = req_valid[0] && req0_ready;
      hs[1] = req_valid[1] && req1_ready;
      if (hs[0] || hs[1]) begin
        r = hs[1] ? 1 : 0;
        exp_q.push_back(alu_ref(req_ctrl[r], req_a[r], req_b[r]));
        owner_q.push_back(r);
        due_q.push_back(cyc + 3);
        iss_cyc = cyc + 1; iss_ctrl = req_ctrl[r]; iss_a = req_a[r]; iss_b = req_b[r];
        idle_from = cyc + 3;
        last = (r == 1);
      end
    end
  end

  // driver
  int         rem[2];
  bit         rnd = 1'b0;
  logic [3:0] ops[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

  task automatic rand_op(input int r);
    req_ctrl[r] = ops[$urandom_range(0, 7)];
    req_a[r]    = $urandom;
    req_b[r]    = ($urandom_range(0, 3) == 0) ? req_a[r] : $urandom;
  endtask

  task automatic set_op(input int r, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    req_ctrl[r] = c; req_a[r] = a; req_b[r] = b; rem[r] = n; req_valid[r] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      if (hs[r]) begin
        rem[r]--;
        if (rnd) begin
          req_valid[r] = ($urandom_range(0, 1) == 1);
          if (req_valid[r]) rand_op(r);
        end else if (rem[r] <= 0) begin
          req_valid[r] = 1'b0;
        end
      end else if (rnd) begin
        if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          req_valid[r] = 1'b1; rand_op(r);
        end else if (req_valid[r] && $urandom_range(0, 15) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit got;
    for (int r = 0; r < 2; r++) begin
      req_valid[r] = 1'b0; req_ctrl[r] = 4'b0000; req_a[r] = '0; req_b[r] = '0; rem[r] = 0;
    end
    run(2);
    reset = 1'b0;
    run(3);
    set_op(0, 4'b0010, 32'd5, 32'd7, 1);
    run(6);
    set_op(0, 4'b0110, 32'd10, 32'd3, 4);
    set_op(1, 4'b0111, 32'd1, 32'd2, 4);
    run(32);
    set_op(1, 4'b1100, 32'd0, 32'd0, 1);
    run(6);
    set_op(1, 4'b1111, 32'd5, 32'd9, 1);
    run(6);
    // reset lands while the accepted op sits in ISSUE
    set_op(0, 4'b0010, 32'd100, 32'd23, 1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = hs[0];
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: req0 never accepted");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(4);
    set_op(0, 4'b0001, 32'hF0, 32'h0F, 1);
    run(6);
    rnd = 1'b1;
    run(3000);
    rnd = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    run(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
